hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Generates the 2-bit operand-select codes that drive the three-way operand muxes of the EX stage, for operand A and operand B.
- Generates stall and flush controls for the 5-stage pipeline.
- Keeps its own shadow copy of destination-register metadata for the EX, MEM and WB stages, so the core datapath does not route pipeline-register fields to it.
- Sits beside the datapath; consumes decode-stage register fields and the EX-stage branch-taken flag.

Parameters:
- REG_ADDR_W, 5, register-index width.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1_d  in  REG_ADDR_W  source register 1 of the instruction in D.
- rs2_d  in  REG_ADDR_W  source register 2 of the instruction in D.
- rd_d  in  REG_ADDR_W  destination register of the instruction in D.
- regwrite_d  in  1  instruction in D writes rd.
- load_d  in  1  instruction in D is a load.
- valid_d  in  1  D holds a real instruction.
- pcsrc_e  in  1  branch or jump taken in EX.
- forward_a_e  out  2  operand-A select: 00 register file, 01 WB result, 10 MEM ALU result.
- forward_b_e  out  2  operand-B select, same encoding.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold the IF/ID register.
- flush_d  out  1  clear the IF/ID register.
- flush_e  out  1  clear the ID/EX register.
- stall_count  out  CNT_W  load-use stall cycles (see Optional Feature).
- flush_count  out  CNT_W  taken-branch flushes (see Optional Feature).

Behaviour:
- Shadow state:
  - E stage: {rs1, rs2, rd, regwrite, load}.
  - M stage: {rd, regwrite}.
  - W stage: {rd, regwrite}.
  - All fields reset to 0, asynchronously on rst_n low.
- Every rising clk edge:
  - W <= M and M <= E, unconditionally.
  - E <= bubble (all zero) if flush_e, or if valid_d is 0.
  - Otherwise E <= D fields.
- Forward select for operand A (operand B identical, using rs2_e):
  - 10 if rs1_e != 0, rs1_e == rd_m and regwrite_m.
  - Else 01 if rs1_e != 0, rs1_e == rd_w and regwrite_w.
  - Else 00.
  - MEM has priority over WB.
  - Code 11 is never driven.
- lw_stall = valid_d & load_e & (rd_e != 0) & (rd_e == rs1_d | rd_e == rs2_d) & ~pcsrc_e.
- Stall and flush outputs:
  - stall_f = stall_d = lw_stall.
  - flush_d = pcsrc_e.
  - flush_e = lw_stall | pcsrc_e.
- All outputs are combinational from the shadow state and inputs; zero added latency.
- The load-use bubble costs exactly 1 cycle: next cycle the load is in M, and the dependent instruction gets forward code 01 once it reaches EX.
- Register x0: never matches; no forward and no stall for index 0.
- Simultaneous pcsrc_e and a hazard: the flush wins. Stalls are suppressed so the PC takes the branch target; D and E are cleared.
- Reset:
  - While rst_n is low, every output is 0, including flush_d, regardless of pcsrc_e.
  - Reset asserted mid-operation clears all in-flight shadow entries at once; no stale forward after release.
- First cycle after reset release: shadow stages are empty, so forwards are 00 until real instructions propagate.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined:
  - stall_count increments on each clk edge where lw_stall = 1.
  - flush_count increments on each edge where pcsrc_e = 1.
  - Both saturate at all-ones and reset to 0 on rst_n low.
- When undefined: both ports are constant 0 and no counter flops exist.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - Struct stage_meta_t {rs1, rs2, rd, regwrite, load}.
  - Constant REG_X0 = 0.
- One sub-module, hazard_stage_reg: a single stage_meta_t register with asynchronous active-low reset and synchronous bubble input.
  - Instantiated three times.
  - M and W instances ignore the rs/load fields.

Test Plan:
- Back-to-back ALU dependency: add x5 (D, cycle 0), then sub using rs1 = x5 (D, cycle 1) -> cycle 2: forward_a_e = 10, no stall.
- Distance-2 dependency: x7 written by instruction at cycle 0, consumer rs2 = x7 in D at cycle 2 -> forward_b_e = 01 at cycle 3.
- Double match: M and W both write x3, consumer rs1 = x3 -> forward_a_e = 10 (MEM priority).
- Load-use: lw x4, then add x6, x4, x1 -> stall_f = stall_d = flush_e = 1 for exactly 1 cycle; next cycle forward_a_e = 01; with HAZARD_PERF_EN, stall_count = 1.
- x0 destination and branch: writes to x0 with a consumer of x0 -> forward 00, no stall; pcsrc_e = 1 concurrent with a load-use pattern in D -> flush_d = flush_e = 1, stall_f = 0, flush_count increments.
- Reset mid-stream: rst_n low while M holds rd = x9 -> all outputs 0; after release, consumer of x9 gets forward 00; counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding unit: operand-select codes, per-stage metadata, x0 index.
package hazard_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             load;
  } stage_meta_t;

  localparam stage_meta_t META_BUBBLE = '0;

  // MEM result is younger than WB, so it must win when both target the same register.
  function automatic fwd_sel_t fwd_select(input logic [REG_W-1:0] rs,
                                          input logic [REG_W-1:0] rd_m, input logic regwrite_m,
                                          input logic [REG_W-1:0] rd_w, input logic regwrite_w);
    fwd_sel_t sel;
    sel = FWD_REG;
    if (rs != REG_X0 && regwrite_m && rs == rd_m)
      sel = FWD_MEM;
    else if (rs != REG_X0 && regwrite_w && rs == rd_w)
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline stage of shadow metadata; 1-cycle register, bubble loads all-zero.
// No backpressure: loads every edge. KEEP_SRC=0 drops the rs/load fields (M and W stages).
module hazard_stage_reg
  import hazard_pkg::*;
#(
  parameter bit KEEP_SRC = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bubble,
  input  stage_meta_t d,
  output stage_meta_t q
);

  stage_meta_t nxt;

  always_comb begin
    nxt = bubble ? META_BUBBLE : d;
    if (!KEEP_SRC) begin
      nxt.rs1  = '0;
      nxt.rs2  = '0;
      nxt.load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= META_BUBBLE;
    else
      q <= nxt;
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// EX operand-forward selects plus load-use stall / branch flush for a 5-stage pipe; outputs combinational.
// No backpressure: shadow E/M/W metadata advances every edge. HAZARD_PERF_EN adds stall/flush counters.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  regwrite_d,
  input  logic                  load_d,
  input  logic                  valid_d,
  input  logic                  pcsrc_e,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  stage_meta_t d_meta, e_q, m_q, w_q;
  fwd_sel_t    fwd_a, fwd_b;
  logic        lw_stall, e_bubble;

  assign d_meta = '{rs1: rs1_d, rs2: rs2_d, rd: rd_d, regwrite: regwrite_d, load: load_d};
  assign e_bubble = flush_e | ~valid_d;

  hazard_stage_reg #(.KEEP_SRC(1'b1)) u_stage_e (
    .clk(clk), .rst_n(rst_n), .bubble(e_bubble), .d(d_meta), .q(e_q)
  );

  hazard_stage_reg #(.KEEP_SRC(1'b0)) u_stage_m (
    .clk(clk), .rst_n(rst_n), .bubble(1'b0), .d(e_q), .q(m_q)
  );

  hazard_stage_reg #(.KEEP_SRC(1'b0)) u_stage_w (
    .clk(clk), .rst_n(rst_n), .bubble(1'b0), .d(m_q), .q(w_q)
  );

  // W is the last stage; its source/load fields are never consumed.
  logic unused_w_fields;
  assign unused_w_fields = ^{w_q.rs1, w_q.rs2, w_q.load};

  assign fwd_a = fwd_select(e_q.rs1, m_q.rd, m_q.regwrite, w_q.rd, w_q.regwrite);
  assign fwd_b = fwd_select(e_q.rs2, m_q.rd, m_q.regwrite, w_q.rd, w_q.regwrite);

  // A taken branch discards D anyway, so it suppresses the load-use stall.
  assign lw_stall = rst_n & valid_d & e_q.load & (e_q.rd != REG_X0) &
                    ((e_q.rd == rs1_d) | (e_q.rd == rs2_d)) & ~pcsrc_e;

  assign forward_a_e = rst_n ? fwd_a : FWD_REG;
  assign forward_b_e = rst_n ? fwd_b : FWD_REG;
  assign stall_f     = lw_stall;
  assign stall_d     = lw_stall;
  assign flush_d     = rst_n & pcsrc_e;
  assign flush_e     = lw_stall | flush_d;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (lw_stall && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_d && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed scenarios plus randomized traffic against a pipeline-history reference model.
module tb_hazard_fwd_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        regwrite_d, load_d, valid_d, pcsrc_e;
  logic [1:0]  forward_a_e, forward_b_e;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic [31:0] stall_count, flush_count;
  logic [7:0]  obs;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .load_d(load_d), .valid_d(valid_d), .pcsrc_e(pcsrc_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e), .stall_count(stall_count), .flush_count(flush_count)
  );

  assign obs = {forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e};

  // Reference model: hist[0] is the instruction in EX, hist[1] in MEM, hist[2] in WB.
  typedef struct {
    bit       rw;
    bit       ld;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit [4:0] rd;
  } ins_t;

  ins_t        hist[$];
  int unsigned m_stalls, m_flushes;

  function automatic ins_t nop_ins();
    ins_t b;
    b.rw = 0; b.ld = 0; b.rs1 = 0; b.rs2 = 0; b.rd = 0;
    return b;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back(nop_ins());
    m_stalls = 0;
    m_flushes = 0;
  endtask

  // Nearest older in-flight producer of rs supplies the value; age 1 = MEM, age 2 = WB.
  function automatic logic [1:0] exp_fwd(input bit [4:0] rs);
    for (int age = 1; age <= 2; age++)
      if (rs != 0 && hist[age].rw && hist[age].rd == rs)
        return (age == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic bit exp_stall();
    return rst_n && valid_d && hist[0].ld && hist[0].rd != 0 &&
           (hist[0].rd == rs1_d || hist[0].rd == rs2_d) && !pcsrc_e;
  endfunction

  function automatic logic [7:0] exp_outs();
    bit s;
    if (!rst_n) return 8'h00;
    s = exp_stall();
    return {exp_fwd(hist[0].rs1), exp_fwd(hist[0].rs2), s, s, pcsrc_e, s | pcsrc_e};
  endfunction

  function automatic logic [31:0] exp_sc();
`ifdef HAZARD_PERF_EN
    return m_stalls;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] exp_fc();
`ifdef HAZARD_PERF_EN
    return m_flushes;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    ins_t e;
    bit   s;
    if (rst_n) begin
      s = exp_stall();
      e = nop_ins();
      if (valid_d && !s && !pcsrc_e) begin
        e.rw = regwrite_d; e.ld = load_d; e.rs1 = rs1_d; e.rs2 = rs2_d; e.rd = rd_d;
      end
      hist.push_front(e);
      void'(hist.pop_back());
      if (s) m_stalls++;
      if (pcsrc_e) m_flushes++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic rw, input logic ld);
    valid_d = v; rs1_d = a; rs2_d = b; rd_d = d; regwrite_d = rw; load_d = ld;
  endtask

  task automatic drain();
    set_d(0, 0, 0, 0, 0, 0);
    pcsrc_e = 0;
    repeat (3) tick();
  endtask

  task automatic reset_pulse();
    rst_n = 0;
    model_reset();
    #1;
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    pcsrc_e = 1;
    set_d(1, 4, 1, 6, 1, 0);
    #2;
    n_cmp++; if (obs !== 8'h00) begin n_err++; $display("FAIL rst_outs: got %b want 00000000", obs); end
    n_cmp++; if (stall_count !== 0 || flush_count !== 0) begin n_err++;
      $display("FAIL rst_counters: got %0d/%0d want 0/0", stall_count, flush_count); end
    rst_n = 1;
    pcsrc_e = 0;
    set_d(1, 5, 6, 7, 1, 0);
    #1;
    n_cmp++; if (obs !== 8'h00) begin n_err++; $display("FAIL post_rst_outs: got %b want 00000000", obs); end
    tick();
  endtask

  task automatic test_back_to_back();
    drain();
    set_d(1, 1, 2, 5, 1, 0);
    tick();
    set_d(1, 5, 6, 8, 1, 0);
    #1;
    n_cmp++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL b2b_nostall: got %b want 0", stall_f); end
    tick();
    set_d(0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (forward_a_e !== 2'b10) begin n_err++; $display("FAIL b2b_fwd_a: got %b want 10", forward_a_e); end
    n_cmp++; if (forward_b_e !== 2'b00) begin n_err++; $display("FAIL b2b_fwd_b: got %b want 00", forward_b_e); end
  endtask

  task automatic test_distance2();
    drain();
    set_d(1, 1, 2, 7, 1, 0);
    tick();
    set_d(1, 1, 2, 10, 1, 0);
    tick();
    set_d(1, 3, 7, 11, 1, 0);
    tick();
    set_d(0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (forward_b_e !== 2'b01) begin n_err++; $display("FAIL dist2_fwd_b: got %b want 01", forward_b_e); end
    n_cmp++; if (forward_a_e !== 2'b00) begin n_err++; $display("FAIL dist2_fwd_a: got %b want 00", forward_a_e); end
  endtask

  task automatic test_double_match();
    drain();
    set_d(1, 1, 2, 3, 1, 0);
    tick();
    set_d(1, 1, 2, 3, 1, 0);
    tick();
    set_d(1, 3, 0, 12, 1, 0);
    tick();
    set_d(0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (forward_a_e !== 2'b10) begin n_err++; $display("FAIL dbl_fwd_a: got %b want 10", forward_a_e); end
    n_cmp++; if (forward_b_e !== 2'b00) begin n_err++; $display("FAIL dbl_fwd_b_x0: got %b want 00", forward_b_e); end
  endtask

  task automatic test_load_use();
    reset_pulse();
    set_d(1, 2, 0, 4, 1, 1);
    tick();
    set_d(1, 4, 1, 6, 1, 0);
    #1;
    n_cmp++; if ({stall_f, stall_d, flush_e, flush_d} !== 4'b1110) begin n_err++;
      $display("FAIL lu_stall: got %b want 1110", {stall_f, stall_d, flush_e, flush_d}); end
    tick();
    n_cmp++; if ({stall_f, stall_d, flush_e, flush_d} !== 4'b0000) begin n_err++;
      $display("FAIL lu_release: got %b want 0000", {stall_f, stall_d, flush_e, flush_d}); end
    tick();
    set_d(0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (forward_a_e !== 2'b01) begin n_err++; $display("FAIL lu_fwd_a: got %b want 01", forward_a_e); end
    n_cmp++; if (stall_count !== exp_sc()) begin n_err++;
      $display("FAIL lu_stall_count: got %0d want %0d", stall_count, exp_sc()); end
  endtask

  task automatic test_x0_branch();
    reset_pulse();
    set_d(1, 1, 2, 0, 1, 0);
    tick();
    set_d(1, 0, 0, 13, 1, 0);
    tick();
    set_d(1, 1, 0, 0, 1, 1);
    #1;
    n_cmp++; if ({forward_a_e, forward_b_e} !== 4'b0000) begin n_err++;
      $display("FAIL x0_fwd: got %b want 0000", {forward_a_e, forward_b_e}); end
    tick();
    set_d(1, 0, 5, 14, 1, 0);
    #1;
    n_cmp++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL x0_nostall: got %b want 0", stall_f); end
    tick();
    set_d(1, 2, 0, 4, 1, 1);
    tick();
    set_d(1, 4, 1, 6, 1, 0);
    pcsrc_e = 1;
    #1;
    n_cmp++; if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0011) begin n_err++;
      $display("FAIL br_flush: got %b want 0011", {stall_f, stall_d, flush_d, flush_e}); end
    tick();
    pcsrc_e = 0;
    set_d(0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (forward_a_e !== 2'b00) begin n_err++; $display("FAIL br_bubble: got %b want 00", forward_a_e); end
    n_cmp++; if (flush_count !== exp_fc()) begin n_err++;
      $display("FAIL br_flush_count: got %0d want %0d", flush_count, exp_fc()); end
  endtask

  task automatic test_reset_midstream();
    drain();
    set_d(1, 1, 2, 9, 1, 0);
    tick();
    set_d(0, 0, 0, 0, 0, 0);
    tick();
    set_d(1, 9, 9, 15, 1, 0);
    pcsrc_e = 1;
    rst_n = 0;
    model_reset();
    #1;
    n_cmp++; if (obs !== 8'h00) begin n_err++; $display("FAIL mid_rst_outs: got %b want 00000000", obs); end
    n_cmp++; if (stall_count !== 0 || flush_count !== 0) begin n_err++;
      $display("FAIL mid_rst_counters: got %0d/%0d want 0/0", stall_count, flush_count); end
    rst_n = 1;
    pcsrc_e = 0;
    #1;
    tick();
    set_d(0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if ({forward_a_e, forward_b_e} !== 4'b0000) begin n_err++;
      $display("FAIL mid_rst_fwd: got %b want 0000", {forward_a_e, forward_b_e}); end
  endtask

  task automatic test_random();
    reset_pulse();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) == 0) reset_pulse();
      set_d(1'($urandom_range(7) != 0), 5'($urandom_range(7)), 5'($urandom_range(7)),
            5'($urandom_range(7)), 1'($urandom_range(3) != 0), 1'($urandom_range(2) == 0));
      pcsrc_e = 1'($urandom_range(9) == 0);
      #1;
      n_cmp++; if (obs !== exp_outs()) begin n_err++;
        $display("FAIL rand_outs[%0d]: got %b want %b", i, obs, exp_outs()); end
      n_cmp++; if (stall_count !== exp_sc() || flush_count !== exp_fc()) begin n_err++;
        $display("FAIL rand_counters[%0d]: got %0d/%0d want %0d/%0d", i, stall_count, flush_count,
                 exp_sc(), exp_fc()); end
      tick();
    end
  endtask

  initial begin
    rst_n = 0;
    pcsrc_e = 0;
    set_d(0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_distance2();
    test_double_match();
    test_load_use();
    test_x0_branch();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
